booth_mult_seq: RTL and testbench



---
 rtl/booth_mult_seq.sv | 123 ++++++++++++
 tb/tb_booth_mult_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential signed radix-2 Booth multiplier with its ripple adder-subtractor
// One add/sub/no-op per clock into an (n+1)-bit accumulator, then an arithmetic right shift.

module booth_addsub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         add_n,
    output logic [W-1:0] sum
);
    logic [W-1:0] b_x;
    logic         c;

    // add_n doubles as carry-in so subtract is a + ~b + 1
    always_comb begin
        b_x = b ^ {W{add_n}};
        c   = add_n;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b_x[i] ^ c;
            c      = (a[i] & b_x[i]) | (c & (a[i] ^ b_x[i]));
        end
    end
endmodule

module booth_mult_seq #(
    parameter int n = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [n-1:0]   multiplicand,
    input  logic [n-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*n-1:0] product
);
    localparam int CW = $clog2(n + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [n:0]     a_q, a_d;
    logic [n-1:0]   q_q, q_d;
    logic           qm1_q, qm1_d;
    logic [n:0]     m_q, m_d;
    logic [CW-1:0]  count_q, count_d;
    logic [2*n-1:0] product_q, product_d;

    logic           add_n;
    logic [n:0]     addsub_sum;
    logic [n:0]     a_sel;

    assign add_n = q_q[0] & ~qm1_q;

    booth_addsub #(.W(n + 1)) u_addsub (
        .a     (a_q),
        .b     (m_q),
        .add_n (add_n),
        .sum   (addsub_sum)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;
        a_sel     = (q_q[0] ^ qm1_q) ? addsub_sum : a_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    m_d     = {multiplicand[n-1], multiplicand};
                    count_d = CW'(n);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = {a_sel[n], a_sel[n:1]};
                q_d     = {a_sel[0], q_q[n-1:1]};
                qm1_d   = q_q[0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    product_d = {a_d[n-1:0], q_d};
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq (n=4 and n=8 instances)
module tb_booth_mult_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start4 = 1'b0;
    logic [3:0]  mc4 = '0, mq4 = '0;
    logic        busy4, done4;
    logic [7:0]  prod4;
    logic        start8 = 1'b0;
    logic [7:0]  mc8 = '0, mq8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  exp4_q[$];
    logic [15:0] exp8_q[$];

    always #5 clk = ~clk;

    booth_mult_seq #(.n(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .multiplicand(mc4), .multiplier(mq4),
        .busy(busy4), .done(done4), .product(prod4)
    );
    booth_mult_seq #(.n(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .multiplicand(mc8), .multiplier(mq8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    function automatic logic [7:0] ref4(input logic signed [3:0] m, input logic signed [3:0] q);
        logic signed [7:0] p;
        p = m * q;
        return p;
    endfunction

    function automatic logic [15:0] ref8(input logic signed [7:0] m, input logic signed [7:0] q);
        logic signed [15:0] p;
        p = m * q;
        return p;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy4, done4, prod4} !== 10'h0) begin
            n_fail++; $display("FAIL reset4 got busy=%b done=%b product=%h want 0/0/00", busy4, done4, prod4);
        end
        n_checks++;
        if ({busy8, done8, prod8} !== 18'h0) begin
            n_fail++; $display("FAIL reset8 got busy=%b done=%b product=%h want 0/0/0000", busy8, done8, prod8);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run4(input logic [3:0] m, input logic [3:0] q, input string name);
        logic [7:0] e;
        @(negedge clk);
        mc4 = m; mq4 = q; start4 = 1'b1;
        exp4_q.push_back(ref4(m, q));
        @(negedge clk);
        start4 = 1'b0;
        mc4 = ~m; mq4 = ~q;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                n_fail++; $display("FAIL %s busy cycle %0d got busy=%b done=%b want 1/0", name, i, busy4, done4);
            end
            @(negedge clk);
        end
        e = exp4_q.pop_front();
        n_checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || prod4 !== e) begin
            n_fail++; $display("FAIL %s done got done=%b busy=%b product=%h want 1/0/%h", name, done4, busy4, prod4, e);
        end
        @(negedge clk);
        n_checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0 || prod4 !== e) begin
            n_fail++; $display("FAIL %s after got done=%b busy=%b product=%h want 0/0/%h", name, done4, busy4, prod4, e);
        end
    endtask

    task automatic test_basic();
        run4(4'd3, 4'd5, "m3xq5");
        run4(4'hD, 4'd5, "mneg3xq5");
        run4(4'd7, 4'h8, "m7xqneg8");
    endtask

    task automatic test_min_operand();
        run4(4'h8, 4'h8, "neg8xneg8");
        run4(4'h8, 4'd1, "neg8x1");
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        @(negedge clk);
        mc4 = 4'd2; mq4 = 4'd3; start4 = 1'b1;
        exp4_q.push_back(ref4(4'd2, 4'd3));
        exp4_q.push_back(ref4(4'hB, 4'd7));
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 0) begin mc4 = 4'hB; mq4 = 4'd7; end
            if (k == 6) begin mc4 = 4'd1; mq4 = 4'd1; start4 = 1'b0; end
            if (k == 4 || k == 10) begin
                e = exp4_q.pop_front();
                n_checks++;
                if (done4 !== 1'b1 || prod4 !== e) begin
                    n_fail++; $display("FAIL b2b edge %0d got done=%b product=%h want 1/%h", k, done4, prod4, e);
                end
            end else begin
                n_checks++;
                if (done4 !== 1'b0) begin
                    n_fail++; $display("FAIL b2b edge %0d done got %b want 0", k, done4);
                end
                n_checks++;
                if (busy4 !== ((k <= 3) || (k >= 6 && k <= 9))) begin
                    n_fail++; $display("FAIL b2b edge %0d busy got %b want %b", k, busy4, (k <= 3) || (k >= 6 && k <= 9));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        mc4 = 4'd5; mq4 = 4'd3; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
            n_fail++; $display("FAIL async_reset got busy=%b done=%b product=%h want 0/0/00", busy4, done4, prod4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (done4 !== 1'b0 || busy4 !== 1'b0 || prod4 !== 8'h00) begin
                n_fail++; $display("FAIL post_reset idle %0d got done=%b busy=%b product=%h want 0/0/00", i, done4, busy4, prod4);
            end
        end
        run4(4'd2, 4'hA, "2xneg6");
    endtask

    task automatic test_regression8();
        logic [7:0]  m, q;
        logic [15:0] e;
        int cyc;
        for (int it = 0; it < 500; it++) begin
            m = 8'($urandom);
            q = 8'($urandom);
            if (it == 0) begin m = 8'h80; q = 8'h80; end
            if (it == 1) begin m = 8'h7F; q = 8'h80; end
            @(negedge clk);
            mc8 = m; mq8 = q; start8 = 1'b1;
            exp8_q.push_back(ref8(m, q));
            @(negedge clk);
            start8 = 1'b0;
            mc8 = 8'($urandom); mq8 = 8'($urandom);
            cyc = 0;
            while (done8 !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            e = exp8_q.pop_front();
            n_checks++;
            if (cyc != 8) begin
                n_fail++; $display("FAIL reg8 latency it=%0d got %0d edges want 8", it, cyc);
            end
            n_checks++;
            if (prod8 !== e) begin
                n_fail++; $display("FAIL reg8 product it=%0d m=%h q=%h got %h want %h", it, m, q, prod8, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_operand();
        test_back_to_back();
        test_async_reset();
        test_regression8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
